// File: rtl/bit_serial_alu_seq_if.sv
// Handshake bundle for bit_serial_alu_seq: request side (operands/op) and response side (result/flags).
// The overflow flag exists only when BSALU_OVF_EN is defined.
interface bit_serial_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
`ifdef BSALU_OVF_EN
  logic             overflow;
`endif

  modport master (
    output in_valid, a, b, op, out_ready,
`ifdef BSALU_OVF_EN
    input  overflow,
`endif
    input  in_ready, out_valid, result, carry, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
`ifdef BSALU_OVF_EN
    output overflow,
`endif
    output in_ready, out_valid, result, carry, zero
  );
endinterface

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: one 1-bit slice evaluated LSB first, carry looped back each clock.
// Define BSALU_OVF_EN to add the registered signed-overflow flag for ADD/SUB.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high
// BUSY   | processing bit idx_q, one bit per edge
// DONE   | result/carry/zero held, out_valid high until out_ready
module bit_serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  bit_serial_alu_seq_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
`ifdef BSALU_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             is_sub, is_arith, is_addsub, last;
  logic             ai, bi, sum_b, cout_b, rbit, less;
  logic [WIDTH-1:0] res_upd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      cy_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef BSALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      cy_q     <= cy_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef BSALU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // The slice: SUB and SLT share the inverted-B adder path with carry-in preloaded to 1.
  always_comb begin
    is_sub    = (op_q == OP_SUB) || (op_q == OP_SLT);
    is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
    is_arith  = is_addsub || (op_q == OP_SLT);
    last      = (idx_q == IDX_LAST);
    ai        = a_q[idx_q];
    bi        = b_q[idx_q] ^ is_sub;
    sum_b     = ai ^ bi ^ cy_q;
    cout_b    = (ai & bi) | (ai & cy_q) | (bi & cy_q);
    less      = sum_b ^ (cy_q ^ cout_b);
    case (op_q)
      OP_AND:         rbit = ai & b_q[idx_q];
      OP_OR:          rbit = ai | b_q[idx_q];
      OP_XOR:         rbit = ai ^ b_q[idx_q];
      OP_NOR:         rbit = ~(ai | b_q[idx_q]);
      OP_ADD, OP_SUB: rbit = sum_b;
      default:        rbit = 1'b0;
    endcase
    res_upd        = result_q;
    res_upd[idx_q] = rbit;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    cy_d     = cy_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef BSALU_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          cy_d    = (bus.op == OP_SUB) || (bus.op == OP_SLT);
          idx_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cy_d     = is_arith ? cout_b : 1'b0;
        result_d = res_upd;
        if (last) begin
          if (op_q == OP_SLT) begin
            result_d = {{(WIDTH-1){1'b0}}, less};
            cy_d     = 1'b0;
          end
          zero_d  = (result_d == '0);
`ifdef BSALU_OVF_EN
          ovf_d   = is_addsub ? (cy_q ^ cout_b) : 1'b0;
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.carry     = cy_q;
  assign bus.zero      = zero_q;
`ifdef BSALU_OVF_EN
  assign bus.overflow  = ovf_q;
`endif
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Self-checking bench for bit_serial_alu_seq at WIDTH=8: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_bit_serial_alu_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bit_serial_alu_seq_if #(.WIDTH(W)) bus();

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                output logic [7:0] r, output logic c, output logic z,
                                output logic v);
    logic [8:0] t;
    r = 8'h00;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0100: r = a ^ b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[7:0];
        c = t[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'b0110: begin
        t = {1'b0, a} + {1'b0, ~b} + 9'd1;
        r = t[7:0];
        c = t[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      default: ;
    endcase
    z = (r == 8'h00);
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input int hold);
    logic [7:0] er;
    logic       ec, ez, ev;
    int         lat;
    model(a, b, op, er, ec, ez, ev);
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a  = a;
    bus.b  = b;
    bus.op = op;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a  = 8'($urandom);
    bus.b  = 8'($urandom);
    bus.op = 4'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 20);
    chk("latency", 32'(lat), 32'd8);
    chk("result", 32'(bus.result), 32'(er));
    chk("carry", 32'(bus.carry), 32'(ec));
    chk("zero", 32'(bus.zero), 32'(ez));
`ifdef BSALU_OVF_EN
    chk("overflow", 32'(bus.overflow), 32'(ev));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      bus.a  = 8'($urandom);
      bus.op = 4'b0010;
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_result", 32'(bus.result), 32'(er));
      chk("hold_carry", 32'(bus.carry), 32'(ec));
      chk("hold_zero", 32'(bus.zero), 32'(ez));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("released_valid", 32'(bus.out_valid), 32'd0);
    chk("released_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] ops [8];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b0111, 4'b1100, 4'b1010};
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a  = '0;
    bus.b  = '0;
    bus.op = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
`ifdef BSALU_OVF_EN
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
`endif

    do_op(8'hFF, 8'h01, 4'b0010, 0);
    do_op(8'h05, 8'h07, 4'b0110, 0);
    do_op(8'h07, 8'h07, 4'b0110, 0);
    do_op(8'hFD, 8'h02, 4'b0111, 0);
    do_op(8'h7F, 8'h80, 4'b0111, 0);
    do_op(8'hF0, 8'h3C, 4'b0000, 5);
    do_op(8'hFF, 8'hFF, 4'b0011, 1);
    do_op(8'h7F, 8'h01, 4'b0010, 0);

    // Abort an ADD after three BUSY edges.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a  = 8'hAA;
    bus.b  = 8'h55;
    bus.op = 4'b0010;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_carry", 32'(bus.carry), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h3C, 8'h0F, 4'b0001, 0);

    for (int n = 0; n < 24; n++) begin
      do_op(8'($urandom), 8'($urandom), ops[$urandom_range(0, 7)], $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
